// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit and its pipeline tracking.
package fetch_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch-to-decode pipeline register contents.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic            valid;
  } if_id_t;

  // Decode-to-execute pipeline register contents.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic            is_branch;
    logic            valid;
  } id_ex_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments when en and inc are both high, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless frozen or already saturated.
  always_comb begin
    count_d = count_q;
    if (en && inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register plus stage-2/stage-3 tracking of fetched PCs and their
// predicted-taken bits, feeding resolution information back to the BTB.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memory_stall,
  input  logic             hazard_stall,
  input  logic [31:0]      btb_branchPC,
  input  logic             btb_flush,
  input  logic             btb_taken,
  input  logic             is_branch_2,
  output logic [31:0]      instructionPC_1,
  output logic [31:0]      pc_2,
  output logic             valid_2,
  output logic [31:0]      instructionPC_3,
  output logic             valid_3,
  output logic             is_branchInst_3,
  output logic             prev_taken_3,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  if_id_t          if_id_q;
  if_id_t          if_id_d;
  id_ex_t          id_ex_q;
  id_ex_t          id_ex_d;

  // Next-state selection: memory stall freezes, flush beats hazard, else advance.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    id_ex_d = id_ex_q;
    if (!memory_stall) begin
      if (btb_flush) begin
        // Only valid bits are cleared; the stale payload is harmless because
        // the outputs that matter are gated by valid_3.
        pc_d          = btb_branchPC;
        if_id_d.valid = 1'b0;
        id_ex_d.valid = 1'b0;
      end else if (hazard_stall) begin
        id_ex_d.valid = 1'b0;
      end else begin
        pc_d              = btb_branchPC;
        if_id_d.pc        = pc_q;
        if_id_d.taken     = btb_taken;
        if_id_d.valid     = 1'b1;
        id_ex_d.pc        = if_id_q.pc;
        id_ex_d.taken     = if_id_q.taken;
        id_ex_d.is_branch = is_branch_2 & if_id_q.valid;
        id_ex_d.valid     = if_id_q.valid;
      end
    end
  end

  // PC and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      if_id_q <= '0;
      id_ex_q <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      id_ex_q <= id_ex_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (!memory_stall),
    .inc   (id_ex_q.valid & id_ex_q.is_branch),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (!memory_stall),
    .inc   (btb_flush),
    .count (mispred_cnt)
  );

  assign instructionPC_1 = pc_q;
  assign pc_2            = if_id_q.pc;
  assign valid_2         = if_id_q.valid;
  assign instructionPC_3 = id_ex_q.pc;
  assign valid_3         = id_ex_q.valid;
  // Bubbles must never look like a taken branch to the BTB.
  assign is_branchInst_3 = id_ex_q.is_branch & id_ex_q.valid;
  assign prev_taken_3    = id_ex_q.taken & id_ex_q.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with small counters so saturation is reachable.
module tb_fetch_pc_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             memory_stall;
  logic             hazard_stall;
  logic [31:0]      btb_branchPC;
  logic             btb_flush;
  logic             btb_taken;
  logic             is_branch_2;
  logic [31:0]      instructionPC_1;
  logic [31:0]      pc_2;
  logic             valid_2;
  logic [31:0]      instructionPC_3;
  logic             valid_3;
  logic             is_branchInst_3;
  logic             prev_taken_3;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .memory_stall    (memory_stall),
    .hazard_stall    (hazard_stall),
    .btb_branchPC    (btb_branchPC),
    .btb_flush       (btb_flush),
    .btb_taken       (btb_taken),
    .is_branch_2     (is_branch_2),
    .instructionPC_1 (instructionPC_1),
    .pc_2            (pc_2),
    .valid_2         (valid_2),
    .instructionPC_3 (instructionPC_3),
    .valid_3         (valid_3),
    .is_branchInst_3 (is_branchInst_3),
    .prev_taken_3    (prev_taken_3),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; memory_stall = 1'b0; hazard_stall = 1'b0; btb_branchPC = 32'h0;
    btb_flush = 1'b0; btb_taken = 1'b0; is_branch_2 = 1'b0;
    tick(); tick();
    chk("rst_pc1",  instructionPC_1, 32'h0);
    chk("rst_pc2",  pc_2, 32'h0);
    chk("rst_v2",   {31'b0, valid_2}, 32'h0);
    chk("rst_pc3",  instructionPC_3, 32'h0);
    chk("rst_v3",   {31'b0, valid_3}, 32'h0);
    chk("rst_br3",  {31'b0, is_branchInst_3}, 32'h0);
    chk("rst_tk3",  {31'b0, prev_taken_3}, 32'h0);
    chk("rst_bcnt", {28'b0, branch_cnt}, 32'h0);
    chk("rst_mcnt", {28'b0, mispred_cnt}, 32'h0);

    // Free run: 0 -> 4 -> 8 -> C
    rst = 1'b0; btb_branchPC = 32'h4;
    tick();
    chk("run1_pc1", instructionPC_1, 32'h4);
    chk("run1_pc2", pc_2, 32'h0);
    chk("run1_v2",  {31'b0, valid_2}, 32'h1);
    chk("run1_v3",  {31'b0, valid_3}, 32'h0);
    btb_branchPC = 32'h8;
    tick();
    chk("run2_pc1", instructionPC_1, 32'h8);
    chk("run2_pc3", instructionPC_3, 32'h0);
    chk("run2_v3",  {31'b0, valid_3}, 32'h1);
    // Fetch at 0x8 predicted taken
    btb_branchPC = 32'hC; btb_taken = 1'b1;
    tick();
    chk("run3_pc1", instructionPC_1, 32'hC);
    chk("run3_pc2", pc_2, 32'h8);
    btb_taken = 1'b0; btb_branchPC = 32'h10; is_branch_2 = 1'b1;
    tick();
    chk("tk_pc1",   instructionPC_1, 32'h10);
    chk("tk_pc3",   instructionPC_3, 32'h8);
    chk("tk_tk3",   {31'b0, prev_taken_3}, 32'h1);
    chk("tk_br3",   {31'b0, is_branchInst_3}, 32'h1);
    chk("tk_bcnt",  {28'b0, branch_cnt}, 32'h0);
    is_branch_2 = 1'b0; btb_branchPC = 32'h14;
    tick();
    chk("adv_pc2",  pc_2, 32'h10);
    chk("adv_bcnt", {28'b0, branch_cnt}, 32'h1);
    chk("adv_tk3",  {31'b0, prev_taken_3}, 32'h0);

    // Hazard stall for two cycles with 0x10 in stage 2
    hazard_stall = 1'b1; is_branch_2 = 1'b1; btb_branchPC = 32'h80;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hz_pc1",  instructionPC_1, 32'h14);
      chk("hz_pc2",  pc_2, 32'h10);
      chk("hz_v2",   {31'b0, valid_2}, 32'h1);
      chk("hz_v3",   {31'b0, valid_3}, 32'h0);
      chk("hz_br3",  {31'b0, is_branchInst_3}, 32'h0);
      chk("hz_bcnt", {28'b0, branch_cnt}, 32'h1);
    end
    hazard_stall = 1'b0; btb_branchPC = 32'h18;
    tick();
    chk("hzr_pc1", instructionPC_1, 32'h18);
    chk("hzr_pc3", instructionPC_3, 32'h10);
    chk("hzr_v3",  {31'b0, valid_3}, 32'h1);
    chk("hzr_br3", {31'b0, is_branchInst_3}, 32'h1);
    is_branch_2 = 1'b0;

    // Memory stall with a valid branch in stage 3; everything frozen
    memory_stall = 1'b1; btb_branchPC = 32'h99; btb_flush = 1'b1; btb_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_pc1",  instructionPC_1, 32'h18);
      chk("ms_pc2",  pc_2, 32'h14);
      chk("ms_pc3",  instructionPC_3, 32'h10);
      chk("ms_v3",   {31'b0, valid_3}, 32'h1);
      chk("ms_bcnt", {28'b0, branch_cnt}, 32'h1);
      chk("ms_mcnt", {28'b0, mispred_cnt}, 32'h0);
    end
    memory_stall = 1'b0; btb_flush = 1'b0; btb_taken = 1'b0; btb_branchPC = 32'h1C;
    tick();
    chk("msr_pc1",  instructionPC_1, 32'h1C);
    chk("msr_pc3",  instructionPC_3, 32'h14);
    chk("msr_bcnt", {28'b0, branch_cnt}, 32'h2);
    btb_branchPC = 32'h20;
    tick();
    chk("msr2_bcnt", {28'b0, branch_cnt}, 32'h2);
    chk("msr2_pc3",  instructionPC_3, 32'h18);

    // Flush and hazard together: flush wins
    btb_flush = 1'b1; hazard_stall = 1'b1; btb_branchPC = 32'h40; btb_taken = 1'b1;
    tick();
    chk("fl_pc1",  instructionPC_1, 32'h40);
    chk("fl_v2",   {31'b0, valid_2}, 32'h0);
    chk("fl_v3",   {31'b0, valid_3}, 32'h0);
    chk("fl_mcnt", {28'b0, mispred_cnt}, 32'h1);
    btb_flush = 1'b0; hazard_stall = 1'b0; btb_taken = 1'b0; btb_branchPC = 32'h44;
    tick();
    chk("fl2_tk3", {31'b0, prev_taken_3}, 32'h0);
    chk("fl2_v3",  {31'b0, valid_3}, 32'h0);
    chk("fl2_pc2", pc_2, 32'h40);
    chk("fl2_v2",  {31'b0, valid_2}, 32'h1);
    btb_branchPC = 32'h48;
    tick();
    chk("fl3_pc3", instructionPC_3, 32'h40);
    chk("fl3_v3",  {31'b0, valid_3}, 32'h1);

    // Reset overrides a simultaneous flush and memory stall
    rst = 1'b1; btb_flush = 1'b1; memory_stall = 1'b1;
    tick();
    chk("rov_pc1",  instructionPC_1, 32'h0);
    chk("rov_v3",   {31'b0, valid_3}, 32'h0);
    chk("rov_pc3",  instructionPC_3, 32'h0);
    chk("rov_mcnt", {28'b0, mispred_cnt}, 32'h0);
    chk("rov_bcnt", {28'b0, branch_cnt}, 32'h0);
    rst = 1'b0; memory_stall = 1'b0;

    // Saturation: 15 flushes reach F, further flushes hold F
    btb_branchPC = 32'h100;
    for (int i = 0; i < 14; i++) tick();
    chk("sat14", {28'b0, mispred_cnt}, 32'hE);
    tick();
    chk("sat15", {28'b0, mispred_cnt}, 32'hF);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sat_hold", {28'b0, mispred_cnt}, 32'hF);
    end
    btb_flush = 1'b0;
    tick();
    chk("sat_end_pc1", instructionPC_1, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-pipeline tracker that sits directly upstream of the BTB. It holds the fetch PC and drives it to the BTB as `instructionPC_1`. It redirects from the BTB's `branchPC`/`flush`, and carries each fetched PC and its predicted-taken bit through decode (stage 2) to execute (stage 3), returning `instructionPC_3`/`prev_taken_3` to the BTB for resolution. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `CNT_W`, 32, width of each performance counter.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memory_stall` in 1: global freeze; no state changes.
- `hazard_stall` in 1: decode hazard (e.g. load-use); hold fetch and stage 2, bubble stage 3.
- `btb_branchPC` in 32: next PC, either predicted or corrected.
- `btb_flush` in 1: stage-3 misprediction; redirect and squash younger instructions.
- `btb_taken` in 1: prediction for the current fetch PC.
- `is_branch_2` in 1: decoder flag, the stage-2 instruction is a conditional branch.
- `instructionPC_1` out 32: current fetch PC.
- `pc_2` out 32: stage-2 PC. `valid_2` out 1: stage-2 valid.
- `instructionPC_3` out 32: stage-3 PC. `valid_3` out 1: stage-3 valid.
- `is_branchInst_3` out 1: stage-3 branch flag, gated by `valid_3`.
- `prev_taken_3` out 1: stage-3 predicted-taken bit, gated by `valid_3`.
- `branch_cnt` out CNT_W: resolved branches.
- `mispred_cnt` out CNT_W: flushes taken.

## Operation
- State:
  - `pc_r`.
  - Stage 2: {pc, taken, valid}.
  - Stage 3: {pc, taken, is_branch, valid}.
  - Two counters.
- Next-state priority, evaluated each cycle:
  1. `rst`: `pc_r`=RESET_PC. All stage fields 0. Counters 0.
  2. `memory_stall`: every register holds, counters included.
  3. `btb_flush`:
     - `pc_r`←`btb_branchPC`.
     - Stage 2 valid←0, stage 3 valid←0. The stage-3 instruction retires; the fetch and stage-2 instructions are squashed.
     - `mispred_cnt`++.
  4. `hazard_stall`: `pc_r` and stage 2 hold; stage 3 valid←0 (bubble).
  5. Normal advance:
     - `pc_r`←`btb_branchPC`.
     - Stage 2←{`pc_r`, `btb_taken`, 1}.
     - Stage 3←{stage-2 pc, stage-2 taken, `is_branch_2`&`valid_2`, `valid_2`}.
- `branch_cnt`++ in any cycle with `!rst`, `!memory_stall`, `valid_3`, and the stage-3 is_branch bit set. This counter is independent of the flush and hazard branches above.
- Both counters saturate at all-ones; they never wrap.
- Flush and hazard asserted together: flush wins; the hazard is dropped because its instruction is squashed.
- Outputs `is_branchInst_3` and `prev_taken_3` are forced to 0 when `!valid_3`, so a bubble can never raise `taken_wrong3`/`target_wrong3` in the BTB.
- PC arithmetic stays in the BTB; this block never adds to the PC.

## Timing
- All outputs are registered values or a combinational AND with a valid bit. There is no input-to-output combinational path, because `btb_flush` depends on `instructionPC_3`/`prev_taken_3`.
- Reset values on all outputs:
  - `instructionPC_1`=RESET_PC.
  - `pc_2`=0, `instructionPC_3`=0.
  - All valid and flag outputs 0; both counters 0.
- A PC fetched in cycle N appears on `pc_2` in N+1 and on `instructionPC_3` in N+2, absent stalls. Each `hazard_stall` cycle adds 1; each `memory_stall` cycle adds 1.
- After reset release, the first valid instruction reaches stage 3 two cycles later.
- Redirect penalty: the flush asserts in cycle N; the target is fetched in N+1 and reaches stage 3 in N+3.
- Reset asserted mid-stall or mid-flush overrides everything in that same cycle.

## Structure
- Shared package `fetch_pkg`:
  - `PC_W`=32.
  - `RESET_PC` default.
  - Packed struct typedefs `if_id_t` {pc, taken, valid} and `id_ex_t` {pc, taken, is_branch, valid}.
- Sub-module `sat_counter` (params `W`; ports clk, rst, en, inc; output count), instantiated twice.

## Test plan
- Reset, then 4 free-running cycles with `btb_branchPC`=PC+4: `instructionPC_1`=0,4,8,C; `instructionPC_3`=0 with `valid_3`=1 in cycle 3; counters=0.
- `btb_taken`=1 fetched at PC 0x8: two cycles later `instructionPC_3`=0x8, `prev_taken_3`=1.
- `btb_flush`=1 with `btb_branchPC`=0x40 and `hazard_stall`=1 in the same cycle:
  - Next cycle: `instructionPC_1`=0x40, `valid_2`=0, `valid_3`=0, `mispred_cnt`=1.
  - The following cycle: `prev_taken_3`=0.
- `hazard_stall` for 2 cycles with `pc_2`=0x10:
  - `instructionPC_1` and `pc_2` hold; `valid_3`=0 for 2 cycles.
  - Then 0x10 reaches stage 3 with `is_branchInst_3` preserved.
- `memory_stall` for 3 cycles during a valid stage-3 branch: all outputs frozen; `branch_cnt` increments exactly once, after release.
- Force `mispred_cnt` near max (CNT_W=4, 15 flushes, then 2 more): count stays at 4'hF.
